tm1638_page_sched: RTL and testbench

- Scheduler that shares the single TM1638 LED/key display between C_NPAGE content sources ("pages").
- Sits between the page producers (counters, status, debug sources) and the TM1638 LED/key driver.
- Debounces the driver's key_values and gives the operator next/prev/auto-rotate navigation.
- An urgent alert forces the alerting page onto the display, with blinking digits.

---
 rtl/tm1638_pkg.sv | 26 ++
 rtl/tm1638_key_debounce.sv | 56 +++++
 rtl/tm1638_page_sched.sv | 243 ++++++++++++++++++++++++
 tb/tb_tm1638_page_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// tm1638_pkg
//    Shared types and constants for the TM1638 page scheduler.
//    state_t      : scheduler FSM states
//    KEY_*        : key lane assignments on the driver's key_values bus
//    SUP_*        : digit-suppress patterns (1 = digit blanked)
//    onehot8()    : page index to one-hot dot pattern
package tm1638_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      ALERT = 2'd2
   } state_t;

   localparam int KEY_NEXT = 0;
   localparam int KEY_PREV = 1;
   localparam int KEY_AUTO = 7;

   localparam logic [7:0] SUP_ALL  = 8'hFF;
   localparam logic [7:0] SUP_NONE = 8'h00;

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'b0000_0001 << idx;
   endfunction

endpackage

// File: rtl/tm1638_key_debounce.sv
// tm1638_key_debounce
//    Eight independent key debouncers evaluated on the 1 ms tick. A lane
//    commits a new level once the raw input has differed from the committed
//    level for C_DEB_TICKS consecutive ticks; any tick where they agree
//    restarts the count.
// Ports
//    clk     in   system clock
//    n_rst   in   asynchronous active-low reset
//    tick    in   1-clk evaluation strobe
//    raw     in   [7:0] raw key levels from the driver
//    stable  out  [7:0] debounced key levels
//    press   out  [7:0] 1-clk pulse where stable[k] goes 0->1
module tm1638_key_debounce
   import tm1638_pkg::*;
#(
   parameter int C_DEB_TICKS = 20
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tick,
   input  logic [7:0] raw,
   output logic [7:0] stable,
   output logic [7:0] press
);

   localparam int DW = $clog2(C_DEB_TICKS + 1);

   logic [DW-1:0] cnt [8];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stable <= '0;
         press  <= '0;
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         press <= '0;
         if (tick) begin
            for (int i = 0; i < 8; i++) begin
               if (raw[i] == stable[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == DW'(C_DEB_TICKS - 1)) begin
                  // this tick is the C_DEB_TICKS-th in a row that disagreed
                  stable[i] <= raw[i];
                  press[i]  <= raw[i];
                  cnt[i]    <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/tm1638_page_sched.sv
// tm1638_page_sched
//    Shares one TM1638 display between C_NPAGE page sources. Debounced keys
//    give next/prev/auto-rotate navigation; an alert forces the lowest
//    alerting page onto the display with blinking digits.
// Ports
//    clk, n_rst         clock, asynchronous active-low reset
//    page_req           [N]    page i has content
//    alert_req          [N]    page i demands forced, blinking display
//    page_data          [32N]  display word of page i at [32i+31:32i]
//    page_leds          [8N]   LED byte of page i
//    page_bcd           [N]    page i wants binary-to-BCD conversion
//    key_values         [8]    raw keys from the driver
//    display_data_o     [32]   to driver display_data_input
//    leds_o, dots_o     [8]    to driver leds_input / dots_input
//    sup_digits_o       [8]    to driver SUP_DIGITS_i (1 = blanked)
//    enable_bin2bcd_o          to driver enable_bin2bcd
//    cur_page           [clog2 N] selected page
//    auto_rot                  auto-rotate enabled
//    key_press          [8]    1-clk pulse per debounced key press
//
// state | meaning
// IDLE  | no page requests; display blanked
// SHOW  | showing cur_page; keys navigate, auto-rotate may advance
// ALERT | showing lowest alerting page, digits blink; NEXT/PREV ignored
module tm1638_page_sched
   import tm1638_pkg::*;
#(
   parameter int C_FCK         = 50_000_000,
   parameter int C_TICK_HZ     = 1000,
   parameter int C_NPAGE       = 4,
   parameter int C_DEB_TICKS   = 20,
   parameter int C_ROT_TICKS   = 2000,
   parameter int C_BLINK_TICKS = 250
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic [C_NPAGE-1:0]           page_req,
   input  logic [C_NPAGE-1:0]           alert_req,
   input  logic [32*C_NPAGE-1:0]        page_data,
   input  logic [8*C_NPAGE-1:0]         page_leds,
   input  logic [C_NPAGE-1:0]           page_bcd,
   input  logic [7:0]                   key_values,
   output logic [31:0]                  display_data_o,
   output logic [7:0]                   leds_o,
   output logic [7:0]                   dots_o,
   output logic [7:0]                   sup_digits_o,
   output logic                         enable_bin2bcd_o,
   output logic [$clog2(C_NPAGE)-1:0]   cur_page,
   output logic                         auto_rot,
   output logic [7:0]                   key_press
);

   localparam int PW   = $clog2(C_NPAGE);
   localparam int TDIV = C_FCK / C_TICK_HZ;
   localparam int TW   = (TDIV > 1) ? $clog2(TDIV) : 1;
   localparam int RW   = $clog2(C_ROT_TICKS + 1);
   localparam int BW   = $clog2(C_BLINK_TICKS + 1);

   // Returns {found, index}: first requesting page scanning away from base
   // (up or down, wrapping); base itself only if nothing else requests.
   function automatic logic [PW:0] search(input logic [PW-1:0]      base,
                                          input logic [C_NPAGE-1:0] req,
                                          input logic               up);
      logic [PW:0] r;
      r = '0;
      if (req[base]) r = {1'b1, base};
      // descending loop so the nearest candidate is written last
      for (int k = C_NPAGE - 1; k >= 1; k--) begin
         int j;
         j = up ? (int'(base) + k) % C_NPAGE
                : (int'(base) - k + C_NPAGE) % C_NPAGE;
         if (req[PW'(j)]) r = {1'b1, PW'(j)};
      end
      return r;
   endfunction

   function automatic logic [PW-1:0] lowest(input logic [C_NPAGE-1:0] req);
      logic [PW-1:0] r;
      r = '0;
      for (int i = C_NPAGE - 1; i >= 0; i--) begin
         if (req[i]) r = PW'(i);
      end
      return r;
   endfunction

   // tick generator
   logic [TW-1:0] tick_cnt;
   logic          tick;

   assign tick = (tick_cnt == TW'(TDIV - 1));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // debounced keys; the level itself is not needed by the scheduler
   logic [7:0] press;
   logic [7:0] unused_key_stable;

   tm1638_key_debounce #(
      .C_DEB_TICKS (C_DEB_TICKS)
   ) u_deb (
      .clk    (clk),
      .n_rst  (n_rst),
      .tick   (tick),
      .raw    (key_values),
      .stable (unused_key_stable),
      .press  (press)
   );

   assign key_press = press;

   // page search candidates
   logic [PW:0]   nxt;
   logic [PW:0]   prv;
   logic [PW:0]   restore_nxt;
   logic [PW-1:0] saved_page;

   assign nxt         = search(cur_page, page_req, 1'b1);
   assign prv         = search(cur_page, page_req, 1'b0);
   assign restore_nxt = search(saved_page, page_req, 1'b1);

   logic nav_next;
   logic nav_prev;

   assign nav_next = press[KEY_NEXT];
   assign nav_prev = press[KEY_PREV];

   state_t        state;
   logic [RW-1:0] rot_cnt;
   logic [BW-1:0] blink_cnt;
   logic          blink_ph;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state            <= IDLE;
         cur_page         <= '0;
         saved_page       <= '0;
         auto_rot         <= 1'b1;
         rot_cnt          <= '0;
         blink_cnt        <= '0;
         blink_ph         <= 1'b0;
         display_data_o   <= '0;
         leds_o           <= '0;
         dots_o           <= '0;
         sup_digits_o     <= SUP_ALL;
         enable_bin2bcd_o <= 1'b0;
      end else begin
         // auto-rotate toggle works in every state, alerts included
         if (press[KEY_AUTO]) auto_rot <= ~auto_rot;

         // output mux: one clk behind cur_page / state / page inputs
         case (state)
            SHOW, ALERT: begin
               display_data_o   <= page_data[{cur_page, 5'd0} +: 32];
               leds_o           <= page_leds[{cur_page, 3'd0} +: 8];
               enable_bin2bcd_o <= page_bcd[cur_page];
               dots_o           <= onehot8(3'(cur_page)) | {auto_rot, 7'd0};
               sup_digits_o     <= (state == ALERT && blink_ph) ? SUP_ALL : SUP_NONE;
            end
            default: begin
               display_data_o   <= '0;
               leds_o           <= '0;
               enable_bin2bcd_o <= 1'b0;
               dots_o           <= '0;
               sup_digits_o     <= SUP_ALL;
            end
         endcase

         if (|alert_req) begin
            if (state != ALERT) begin
               saved_page <= cur_page;
               blink_cnt  <= '0;
               blink_ph   <= 1'b0;
            end else if (tick) begin
               if (blink_cnt == BW'(C_BLINK_TICKS - 1)) begin
                  blink_cnt <= '0;
                  blink_ph  <= ~blink_ph;
               end else begin
                  blink_cnt <= blink_cnt + 1'b1;
               end
            end
            state    <= ALERT;
            cur_page <= lowest(alert_req);
         end else begin
            case (state)
               IDLE: begin
                  if (|page_req) begin
                     state    <= SHOW;
                     cur_page <= lowest(page_req);
                     rot_cnt  <= '0;
                  end
               end
               ALERT: begin
                  rot_cnt <= '0;
                  if (page_req[saved_page]) begin
                     state    <= SHOW;
                     cur_page <= saved_page;
                  end else if (restore_nxt[PW]) begin
                     state    <= SHOW;
                     cur_page <= restore_nxt[PW-1:0];
                  end else begin
                     state <= IDLE;
                  end
               end
               SHOW: begin
                  if (!page_req[cur_page]) begin
                     rot_cnt <= '0;
                     if (nxt[PW]) begin
                        cur_page <= nxt[PW-1:0];
                     end else begin
                        state <= IDLE;
                     end
                  end else if (nav_next || nav_prev) begin
                     // key wins over a coincident timer expiry
                     rot_cnt <= '0;
                     if (nav_next && !nav_prev) begin
                        cur_page <= nxt[PW-1:0];
                     end else if (nav_prev && !nav_next) begin
                        cur_page <= prv[PW-1:0];
                     end
                  end else if (auto_rot && tick) begin
                     if (rot_cnt == RW'(C_ROT_TICKS - 1)) begin
                        rot_cnt  <= '0;
                        cur_page <= nxt[PW-1:0];
                     end else begin
                        rot_cnt <= rot_cnt + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tm1638_page_sched.sv
module tb_tm1638_page_sched;

   logic         clk;
   logic         n_rst;
   logic [3:0]   page_req;
   logic [3:0]   alert_req;
   logic [127:0] page_data;
   logic [31:0]  page_leds;
   logic [3:0]   page_bcd;
   logic [7:0]   key_values;
   logic [31:0]  display_data_o;
   logic [7:0]   leds_o;
   logic [7:0]   dots_o;
   logic [7:0]   sup_digits_o;
   logic         enable_bin2bcd_o;
   logic [1:0]   cur_page;
   logic         auto_rot;
   logic [7:0]   key_press;

   int n_checks = 0;
   int n_errors = 0;

   tm1638_page_sched #(
      .C_FCK         (1000),
      .C_TICK_HZ     (100),
      .C_NPAGE       (4),
      .C_DEB_TICKS   (3),
      .C_ROT_TICKS   (5),
      .C_BLINK_TICKS (2)
   ) dut (
      .clk              (clk),
      .n_rst            (n_rst),
      .page_req         (page_req),
      .alert_req        (alert_req),
      .page_data        (page_data),
      .page_leds        (page_leds),
      .page_bcd         (page_bcd),
      .key_values       (key_values),
      .display_data_o   (display_data_o),
      .leds_o           (leds_o),
      .dots_o           (dots_o),
      .sup_digits_o     (sup_digits_o),
      .enable_bin2bcd_o (enable_bin2bcd_o),
      .cur_page         (cur_page),
      .auto_rot         (auto_rot),
      .key_press        (key_press)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic press_keys(input logic [7:0] mask, input int hold, output int pulses);
      pulses = 0;
      key_values = mask;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if ((key_press & mask) != 8'h00) pulses++;
      end
      key_values = 8'h00;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((key_press & mask) != 8'h00) pulses++;
      end
   endtask

   task automatic wait_cur_change(input int bound, output int cyc);
      logic [1:0] prev;
      prev = cur_page;
      cyc = 0;
      while (cur_page == prev && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_sup_change(input int bound, output int cyc);
      logic [7:0] prev;
      prev = sup_digits_o;
      cyc = 0;
      while (sup_digits_o == prev && cyc < bound) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int pulses;

      n_rst      = 1'b0;
      page_req   = 4'b0000;
      alert_req  = 4'b0000;
      page_data  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h12345678};
      page_leds  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      page_bcd   = 4'b0100;
      key_values = 8'h00;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_cur_page", 32'(cur_page), 32'd0);
      chk("rst_auto_rot", 32'(auto_rot), 32'd1);
      chk("rst_sup", 32'(sup_digits_o), 32'h0000_00FF);
      chk("rst_display", display_data_o, 32'h0);
      chk("rst_leds", 32'(leds_o), 32'h0);
      chk("rst_dots", 32'(dots_o), 32'h0);
      chk("rst_bcd", 32'(enable_bin2bcd_o), 32'h0);
      chk("rst_key_press", 32'(key_press), 32'h0);

      // IDLE -> SHOW on lowest requesting page; outputs one clk later
      n_rst    = 1'b1;
      page_req = 4'b0101;
      @(negedge clk);
      chk("show_cur_page", 32'(cur_page), 32'd0);
      @(negedge clk);
      chk("show_display", display_data_o, 32'h12345678);
      chk("show_dots", 32'(dots_o), 32'h81);
      chk("show_sup", 32'(sup_digits_o), 32'h00);
      chk("show_leds", 32'(leds_o), 32'hA0);

      // auto-rotate over 1011: 0 -> 1 -> 3 -> 0, 50 clk apart
      page_req = 4'b1011;
      wait_cur_change(70, cyc);
      chk("rot_first_in_time", 32'(cyc <= 60), 32'd1);
      chk("rot_first_page", 32'(cur_page), 32'd1);
      wait_cur_change(70, cyc);
      chk("rot_second_page", 32'(cur_page), 32'd3);
      chk("rot_second_period", 32'(cyc), 32'd50);
      wait_cur_change(70, cyc);
      chk("rot_wrap_page", 32'(cur_page), 32'd0);
      chk("rot_wrap_period", 32'(cyc), 32'd50);

      // key7 disables auto-rotate before the next expiry
      press_keys(8'h80, 40, pulses);
      chk("auto_key_pulses", 32'(pulses), 32'd1);
      chk("auto_off", 32'(auto_rot), 32'd0);
      chk("auto_off_dots", 32'(dots_o), 32'h01);
      wait_cur_change(120, cyc);
      chk("frozen_cycles", 32'(cyc), 32'd120);
      chk("frozen_page", 32'(cur_page), 32'd0);

      // NEXT skips non-requesting page 1; PREV wraps downward
      page_req = 4'b0101;
      press_keys(8'h01, 40, pulses);
      chk("next_pulses", 32'(pulses), 32'd1);
      chk("next_page", 32'(cur_page), 32'd2);
      press_keys(8'h02, 40, pulses);
      chk("prev_page", 32'(cur_page), 32'd0);
      press_keys(8'h02, 40, pulses);
      chk("prev_wrap_page", 32'(cur_page), 32'd2);

      // 2-tick glitch is rejected
      press_keys(8'h01, 20, pulses);
      chk("glitch_pulses", 32'(pulses), 32'd0);
      chk("glitch_page", 32'(cur_page), 32'd2);

      // NEXT and PREV together: pulse but no move
      press_keys(8'h03, 40, pulses);
      chk("both_pulses", 32'(pulses), 32'd1);
      chk("both_page", 32'(cur_page), 32'd2);

      // current page drops: advance by next rule (3 -> wraps to 1)
      page_req = 4'b1011;
      @(negedge clk);
      chk("drop_next_page", 32'(cur_page), 32'd3);
      page_req = 4'b0010;
      @(negedge clk);
      chk("drop_wrap_page", 32'(cur_page), 32'd1);
      page_req = 4'b1011;

      // alert on page 2 from page 1
      alert_req = 4'b0100;
      @(negedge clk);
      chk("alert_cur_page", 32'(cur_page), 32'd2);
      @(negedge clk);
      chk("alert_sup_start", 32'(sup_digits_o), 32'h00);
      chk("alert_display", display_data_o, 32'h22222222);
      chk("alert_dots", 32'(dots_o), 32'h04);
      chk("alert_bcd", 32'(enable_bin2bcd_o), 32'd1);
      wait_sup_change(30, cyc);
      chk("blink_first_in_time", 32'(cyc <= 20), 32'd1);
      chk("blink_first_val", 32'(sup_digits_o), 32'hFF);
      wait_sup_change(30, cyc);
      chk("blink_period", 32'(cyc), 32'd20);
      chk("blink_second_val", 32'(sup_digits_o), 32'h00);
      press_keys(8'h01, 40, pulses);
      chk("alert_key_pulses", 32'(pulses), 32'd1);
      chk("alert_key_ignored", 32'(cur_page), 32'd2);

      // alert clears: saved page 1 restored
      alert_req = 4'b0000;
      @(negedge clk);
      chk("restore_page", 32'(cur_page), 32'd1);
      @(negedge clk);
      chk("restore_sup", 32'(sup_digits_o), 32'h00);
      chk("restore_display", display_data_o, 32'h11111111);
      chk("restore_bcd", 32'(enable_bin2bcd_o), 32'd0);

      // no page requests -> IDLE, blanked
      page_req = 4'b0000;
      repeat (2) @(negedge clk);
      chk("idle_sup", 32'(sup_digits_o), 32'hFF);
      chk("idle_leds", 32'(leds_o), 32'h00);
      chk("idle_dots", 32'(dots_o), 32'h00);

      // asynchronous reset in the middle of an alert
      alert_req = 4'b0001;
      repeat (3) @(negedge clk);
      chk("alert2_sup", 32'(sup_digits_o), 32'h00);
      chk("alert2_display", display_data_o, 32'h12345678);
      n_rst = 1'b0;
      #1;
      chk("async_rst_sup", 32'(sup_digits_o), 32'hFF);
      chk("async_rst_display", display_data_o, 32'h0);
      chk("async_rst_dots", 32'(dots_o), 32'h00);
      chk("async_rst_leds", 32'(leds_o), 32'h00);
      chk("async_rst_auto_rot", 32'(auto_rot), 32'd1);
      chk("async_rst_cur_page", 32'(cur_page), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
